// File: rtl/ntt_cmd_ctrl.sv
// ntt_cmd_ctrl: command-side sequencer for the radix-4 NTT address/control FSM.
// Accepts NTT / PWM / INTT commands over valid/ready and drives the 3-bit conf
// code. It holds the run code until the FSM reports the end of the operation.
// It then holds the DONE code for DRAIN_CYCLES to flush the write pipeline, and
// finally pulses done.
// Optional feature: define NTT_CMD_WDOG_EN to add a RUN-state watchdog. On
// expiry the watchdog forces the drain sequence and flags err together with done.
module ntt_cmd_ctrl #(
  parameter int DRAIN_CYCLES = 14,
  parameter int WDOG_LIMIT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic [2:0] conf,
  input  logic [3:0] done_flag,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_op,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state;
  logic [2:0]    conf_q;
  logic [1:0]    op_q;
  logic [CW-1:0] drain_cnt;
  logic          accept;
  logic          target_hit;
  logic [2:0]    drain_code;
  logic          wdog_expired;
  logic          abort_flag;

  assign accept     = (state == S_IDLE) && cmd_valid && (cmd_op != 2'b11);
  // op_q only ever holds 0..2, which selects bit0/bit1/bit2 of done_flag
  assign target_hit = (state == S_RUN) && done_flag[op_q];
  assign drain_code = (op_q == 2'b10) ? 3'd5 : 3'd4;

  // The final-iteration flag switches conf in the same cycle, so the FSM's own
  // registered copy of conf never sees an extra run cycle.
  assign conf = target_hit ? drain_code : conf_q;

`ifdef NTT_CMD_WDOG_EN
  logic [9:0] wdog_cnt;
  logic       abort_q;

  assign wdog_expired = (state == S_RUN) && !done_flag[op_q] &&
                        (wdog_cnt == 10'(WDOG_LIMIT - 1));
  assign abort_flag   = abort_q;

  // Watchdog: counts RUN cycles of the current command and remembers an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      abort_q  <= 1'b0;
    end else if (accept) begin
      wdog_cnt <= '0;
      abort_q  <= 1'b0;
    end else if (state == S_RUN) begin
      wdog_cnt <= wdog_cnt + 10'd1;
      if (wdog_expired) abort_q <= 1'b1;
    end
  end
`else
  // WDOG_LIMIT only matters when the watchdog is built.
  logic [9:0] unused_wdog_limit;
  assign unused_wdog_limit = 10'(WDOG_LIMIT);
  assign wdog_expired      = 1'b0;
  assign abort_flag        = 1'b0;
`endif

  // Main sequencer: state, drain timer, latched op and registered host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      conf_q    <= 3'd0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_op   <= 2'b00;
      err       <= 1'b0;
      drain_cnt <= '0;
      op_q      <= 2'b00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op != 2'b11) begin
              op_q      <= cmd_op;
              conf_q    <= {1'b0, cmd_op} + 3'd1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= S_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (target_hit || wdog_expired) begin
            conf_q    <= drain_code;
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            conf_q  <= 3'd0;
            done    <= 1'b1;
            done_op <= op_q;
            err     <= abort_flag;
            state   <= S_RESP;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        S_RESP: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
